// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS
//   common-anode digits. Each digit owns a slot of CLKS_PER_DIGIT clocks:
//   the first BLANK_CYCLES clocks keep every anode off (anti-ghosting), the
//   rest drive the digit's anode. The displayed value only changes at a
//   frame boundary, so a frame never shows a mix of old and new digits.
//   Leading zero digits can be suppressed (digit 0 is always shown).
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   value_in     nibble i = digit i, digit 0 least significant
//   load         1-cycle strobe, captures value_in for the next frame
//   digit_en     per-digit enable; a disabled digit stays dark but keeps its slot
//   digit_code   nibble for the decoder input
//   blank        1 = segments must be off
//   anodes       active-low anode enables, at most one bit low
//   frame_start  1-cycle pulse on the first cycle of the digit 0 slot
module seven_segment_scanner #(
   parameter int NUM_DIGITS     = 4,
   parameter int CLKS_PER_DIGIT = 50000,
   parameter int BLANK_CYCLES   = 500,
   parameter int LZ_SUPPRESS    = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   output logic [3:0]              digit_code,
   output logic                    blank,
   output logic [NUM_DIGITS-1:0]   anodes,
   output logic                    frame_start
);

   localparam int CW = $clog2(CLKS_PER_DIGIT);
   localparam int IW = $clog2(NUM_DIGITS);

   localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_DIGIT - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_DRIVE = 1'b1;

   logic [0:0]              state_q, state_d;
   logic [CW-1:0]           counter_q, counter_d;
   logic [IW-1:0]           index_q, index_d;
   logic [4*NUM_DIGITS-1:0] display_q, display_d;
   logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
   logic                    pendValid_q, pendValid_d;
   logic                    run_q;
   logic [3:0]              digitCode_d;
   logic                    blank_d;
   logic [NUM_DIGITS-1:0]   anodes_d;
   logic                    frameStart_d;
   logic                    slotEnd;
   logic                    boundary;
   logic [NUM_DIGITS-1:0]   darkVec;

   // Slot sequencing. run_q is low only on the first edge after reset, which
   // makes that edge behave as a frame boundary entering slot 0 at count 0,
   // so the first frame after reset starts (and pulses frame_start) at once.
   always_comb begin
      slotEnd   = run_q && (counter_q == CNT_LAST);
      counter_d = (run_q && !slotEnd) ? counter_q + CW'(1) : '0;
      index_d   = index_q;
      if (slotEnd) begin
         index_d = (index_q == IDX_LAST) ? '0 : index_q + IW'(1);
      end
      state_d = state_q;
      if (state_q == ST_BLANK && run_q && counter_q == BLANK_LAST) begin
         state_d = ST_DRIVE;
      end else if (state_q == ST_DRIVE && slotEnd) begin
         state_d = ST_BLANK;
      end
      boundary = (state_d == ST_BLANK) && (counter_d == '0) && (index_d == '0);
   end

   // Double-buffered value. Loads go to the pending buffer and are promoted
   // on the frame boundary; a load on the boundary edge itself bypasses the
   // pending buffer so that frame already shows it.
   always_comb begin
      display_d   = display_q;
      pending_d   = pending_q;
      pendValid_d = pendValid_q;
      if (boundary) begin
         if (load) begin
            display_d   = value_in;
            pending_d   = value_in;
            pendValid_d = 1'b0;
         end else if (pendValid_q) begin
            display_d   = pending_q;
            pendValid_d = 1'b0;
         end
      end else if (load) begin
         pending_d   = value_in;
         pendValid_d = 1'b1;
      end
   end

   // Dark digits: disabled, or (with suppression) a non-zero position whose
   // nibble and every more significant nibble are zero. Scanning from the
   // top down lets one running flag carry the "all zero above" condition.
   always_comb begin
      logic allZero;
      allZero = 1'b1;
      darkVec = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         allZero    = allZero && (display_d[4*i +: 4] == 4'h0);
         darkVec[i] = !digit_en[i] || ((LZ_SUPPRESS == 1) && (i > 0) && allZero);
      end
   end

   // Outputs are computed from next-state values so they change on the same
   // edge as the counter and state they describe.
   always_comb begin
      digitCode_d  = display_d[4*index_d +: 4];
      blank_d      = (state_d == ST_BLANK) || darkVec[index_d];
      frameStart_d = boundary;
      anodes_d     = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!blank_d && index_d == IW'(i)) begin
            anodes_d[i] = 1'b0;
         end
      end
   end

   // State, buffers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_BLANK;
         counter_q   <= '0;
         index_q     <= '0;
         display_q   <= '0;
         pending_q   <= '0;
         pendValid_q <= 1'b0;
         run_q       <= 1'b0;
         digit_code  <= 4'h0;
         blank       <= 1'b1;
         anodes      <= '1;
         frame_start <= 1'b0;
      end else begin
         state_q     <= state_d;
         counter_q   <= counter_d;
         index_q     <= index_d;
         display_q   <= display_d;
         pending_q   <= pending_d;
         pendValid_q <= pendValid_d;
         run_q       <= 1'b1;
         digit_code  <= digitCode_d;
         blank       <= blank_d;
         anodes      <= anodes_d;
         frame_start <= frameStart_d;
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
//   Directed bench for the scanner with 4 digits, 8 clocks per slot and
//   2 blank clocks. Cycle numbers count edges after reset release; cycle c
//   belongs to digit (c/8)%4 at slot count c%8.
module tb_seven_segment_scanner;

   logic        clk;
   logic        reset;
   logic [15:0] value_in;
   logic        load;
   logic [3:0]  digit_en;
   logic [3:0]  digit_code;
   logic        blank;
   logic [3:0]  anodes;
   logic        frame_start;

   int total;
   int bad;
   int cyc;

   seven_segment_scanner #(
      .NUM_DIGITS    (4),
      .CLKS_PER_DIGIT(8),
      .BLANK_CYCLES  (2),
      .LZ_SUPPRESS   (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .value_in   (value_in),
      .load       (load),
      .digit_en   (digit_en),
      .digit_code (digit_code),
      .blank      (blank),
      .anodes     (anodes),
      .frame_start(frame_start)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   // Advance one edge, sample on the falling edge, and compare against the
   // expected display for the given shown value and enables.
   task automatic applyStimulus(input logic [15:0] disp, input logic [3:0] en);
      int          dig;
      int          cnt;
      logic [15:0] upper;
      logic        dark;
      logic        drive;
      logic [3:0]  expAn;
      @(posedge clk);
      @(negedge clk);
      dig   = (cyc / 8) % 4;
      cnt   = cyc % 8;
      upper = disp >> (4 * dig);
      dark  = !en[dig] || (dig > 0 && upper == 16'h0);
      drive = (cnt >= 2);
      expAn = 4'hF;
      if (drive && !dark) expAn[dig] = 1'b0;
      checkOutput("anodes", {12'h0, anodes}, {12'h0, expAn});
      checkOutput("blank", {15'h0, blank}, {15'h0, !drive || dark});
      checkOutput("code", {12'h0, digit_code}, {12'h0, upper[3:0]});
      checkOutput("fstart", {15'h0, frame_start}, {15'h0, (cyc % 32) == 0});
      cyc++;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      cyc      = 0;
      reset    = 1'b1;
      load     = 1'b0;
      value_in = 16'h0;
      digit_en = 4'hF;

      // Reset held three cycles.
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("rst_an", {12'h0, anodes}, 16'h000F);
         checkOutput("rst_blank", {15'h0, blank}, 16'h0001);
         checkOutput("rst_fs", {15'h0, frame_start}, 16'h0000);
      end
      reset = 1'b0;

      // Frame 0: load 1234 on the boundary edge, then several mid-frame
      // loads (last one, ABCD, wins) that must not tear this frame.
      for (int c = 0; c < 32; c++) begin
         load = 1'b0;
         if (c == 0)  begin load = 1'b1; value_in = 16'h1234; end
         if (c == 10) begin load = 1'b1; value_in = 16'hABCD; end
         if (c == 12) begin load = 1'b1; value_in = 16'h5555; end
         if (c == 14) begin load = 1'b1; value_in = 16'hABCD; end
         applyStimulus(16'h1234, 4'hF);
         if (c == 2) begin
            checkOutput("d0_an", {12'h0, anodes}, 16'h000E);
            checkOutput("d0_code", {12'h0, digit_code}, 16'h0004);
         end
         if (c == 26) checkOutput("d3_an", {12'h0, anodes}, 16'h0007);
      end

      // Frame 1: ABCD; queue 0050 for frame 2.
      for (int c = 32; c < 64; c++) begin
         load = 1'b0;
         if (c == 40) begin load = 1'b1; value_in = 16'h0050; end
         applyStimulus(16'hABCD, 4'hF);
      end

      // Frame 2: 0050 with digits 3 and 2 suppressed; queue 0000.
      for (int c = 64; c < 96; c++) begin
         load = 1'b0;
         if (c == 70) begin load = 1'b1; value_in = 16'h0000; end
         applyStimulus(16'h0050, 4'hF);
         if (c == 84) checkOutput("lz_d2_an", {12'h0, anodes}, 16'h000F);
      end

      // Frame 3: 0000, only digit 0 lit.
      for (int c = 96; c < 128; c++) begin
         load = 1'b0;
         applyStimulus(16'h0000, 4'hF);
      end

      // Frame 4: boundary load of 1234 with digit 2 disabled.
      for (int c = 128; c < 160; c++) begin
         load = 1'b0;
         digit_en = 4'b1011;
         if (c == 128) begin load = 1'b1; value_in = 16'h1234; end
         applyStimulus(16'h1234, 4'b1011);
         if (c == 148) checkOutput("en_d2_blank", {15'h0, blank}, 16'h0001);
      end

      // Frame 5: enables restored, run into digit 2 drive phase.
      digit_en = 4'hF;
      load     = 1'b0;
      for (int c = 160; c < 181; c++) begin
         applyStimulus(16'h1234, 4'hF);
      end
      checkOutput("pre_rst_an", {12'h0, anodes}, 16'h000B);

      // Reset mid-slot aborts at once.
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("mid_rst_an", {12'h0, anodes}, 16'h000F);
      checkOutput("mid_rst_blank", {15'h0, blank}, 16'h0001);
      checkOutput("mid_rst_code", {12'h0, digit_code}, 16'h0000);
      checkOutput("mid_rst_fs", {15'h0, frame_start}, 16'h0000);

      // After release the frame restarts from digit 0 with a cleared display.
      reset = 1'b0;
      cyc   = 0;
      for (int c = 0; c < 33; c++) begin
         applyStimulus(16'h0000, 4'hF);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
